// File: rtl/isp_pkg.sv
// Shared ISP definitions: feeder state encoding and the kernel-derived flush
// geometry that keeps the feeder and the demosaic stages in agreement.
package isp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } feeder_state_t;

  function automatic int unsigned boundary_width(input int unsigned kernel_size);
    return (kernel_size - 1) / 2;
  endfunction

  function automatic int unsigned flush_rows(input int unsigned kernel_size);
    return 2 + boundary_width(kernel_size) - 1;
  endfunction

endpackage

// File: rtl/bayer_frame_feeder_if.sv
// Pixel stream bundle: source side (iData/iValid/oReady) and the
// demosaic-facing side (oData/oValid, no backpressure).
interface bayer_frame_feeder_if;
  logic [7:0] iData;
  logic       iValid;
  logic       oReady;
  logic [7:0] oData;
  logic       oValid;

  modport master (output iData, iValid, input oReady, oData, oValid);
  modport slave  (input iData, iValid, output oReady, oData, oValid);
endinterface

// File: rtl/frame_pos_counter.sv
// Raster x/y position counter with enable, clear and a last-pixel flag.
module frame_pos_counter #(
  parameter int unsigned width  = 1920,
  parameter int unsigned height = 1080
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        clr,
  output logic [15:0] x,
  output logic [15:0] y,
  output logic        last
);

  localparam logic [15:0] XMAX = 16'(width - 1);
  localparam logic [15:0] YMAX = 16'(height - 1);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      x <= '0;
      y <= '0;
    end else if (en) begin
      if (x == XMAX) begin
        x <= '0;
        y <= (y == YMAX) ? '0 : y + 16'd1;
      end else begin
        x <= x + 16'd1;
      end
    end
  end

  assign last = (x == XMAX) && (y == YMAX);

endmodule

// File: rtl/bayer_frame_feeder.sv
// Feeds demosaic one frame at a time: source pixels 1:1, then width*flushRows
// zero pixels to drain the line buffers, then a one-cycle done pulse.
module bayer_frame_feeder
  import isp_pkg::*;
#(
  parameter int unsigned width      = 1920,
  parameter int unsigned height     = 1080,
  parameter int unsigned kernelSize = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 iStart,
  bayer_frame_feeder_if.slave  px,
  output logic                 oBusy,
  output logic [15:0]          oX,
  output logic [15:0]          oY,
  output logic [15:0]          oFrameCnt,
  output logic                 oDone
);

  localparam int unsigned flushRows = flush_rows(kernelSize);
  localparam int unsigned FLUSH_PIX = width * flushRows;
  localparam int unsigned FCW       = $clog2(FLUSH_PIX + 1);
  localparam logic [FCW-1:0] FLUSH_LAST = FCW'(FLUSH_PIX - 1);

  feeder_state_t  state, state_nxt;
  logic [FCW-1:0] flushCnt;
  logic [15:0]    pos_x, pos_y;
  logic           pos_last;
  logic           xfer;

  frame_pos_counter #(
    .width  (width),
    .height (height)
  ) u_pos (
    .clk   (clk),
    .reset (reset),
    .en    (xfer),
    .clr   ((state == IDLE) && iStart),
    .x     (pos_x),
    .y     (pos_y),
    .last  (pos_last)
  );

  always_comb begin
    state_nxt = state;
    px.oReady = (state == FRAME);
    oBusy     = (state == FRAME) || (state == FLUSH);
    xfer      = px.iValid && (state == FRAME);
    case (state)
      IDLE:    if (iStart) state_nxt = FRAME;
      FRAME:   if (xfer && pos_last) state_nxt = FLUSH;
      FLUSH:   if (flushCnt == FLUSH_LAST) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      px.oData  <= '0;
      px.oValid <= 1'b0;
      oDone     <= 1'b0;
      oFrameCnt <= '0;
      flushCnt  <= '0;
      oX        <= '0;
      oY        <= '0;
    end else begin
      state     <= state_nxt;
      px.oValid <= 1'b0;
      oDone     <= 1'b0;
      case (state)
        IDLE: begin
          if (iStart) begin
            oX <= '0;
            oY <= '0;
          end
        end
        FRAME: begin
          flushCnt <= '0;
          // oX/oY report the pixel just accepted, i.e. the counter before it advances
          if (xfer) begin
            px.oData  <= px.iData;
            px.oValid <= 1'b1;
            oX        <= pos_x;
            oY        <= pos_y;
          end
        end
        FLUSH: begin
          px.oData  <= '0;
          px.oValid <= 1'b1;
          flushCnt  <= flushCnt + FCW'(1);
        end
        DONE: begin
          oDone     <= 1'b1;
          oFrameCnt <= oFrameCnt + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bayer_frame_feeder.sv
// Bench for bayer_frame_feeder at width=4, height=2, kernelSize=7.
module tb_bayer_frame_feeder;
  import isp_pkg::*;

  localparam int W    = 4;
  localparam int H    = 2;
  localparam int NPIX = W * H;
  localparam int NZ   = W * 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        iStart = 1'b0;
  logic        oBusy, oDone;
  logic [15:0] oX, oY, oFrameCnt;

  bayer_frame_feeder_if bus();

  bayer_frame_feeder #(
    .width      (W),
    .height     (H),
    .kernelSize (7)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .iStart    (iStart),
    .px        (bus.slave),
    .oBusy     (oBusy),
    .oX        (oX),
    .oY        (oY),
    .oFrameCnt (oFrameCnt),
    .oDone     (oDone)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // reference model: counts of accepted pixels and emitted zeros per frame
  bit         m_act = 0, m_fin = 0;
  int         m_acc = 0, m_z = 0;
  bit         e_valid = 0, e_done = 0;
  logic [7:0] e_data = '0;
  int         e_fc = 0, e_x = 0, e_y = 0;

  int nv_run = 0, gap_seen = -1;
  bit after_done = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit s, input bit v, input logic [7:0] d);
    @(negedge clk);
    reset = r; iStart = s; bus.iValid = v; bus.iData = d;
    e_done = 0;
    if (r) begin
      m_act = 0; m_fin = 0; m_acc = 0; m_z = 0;
      e_valid = 0; e_data = '0; e_fc = 0; e_x = 0; e_y = 0;
    end else if (m_fin) begin
      m_fin = 0; e_valid = 0; e_done = 1; e_fc = (e_fc + 1) % 65536;
    end else if (!m_act) begin
      e_valid = 0;
      if (s) begin
        m_act = 1; m_acc = 0; m_z = 0; e_x = 0; e_y = 0;
      end
    end else if (m_acc < NPIX) begin
      if (v) begin
        e_valid = 1; e_data = d; e_x = m_acc % W; e_y = m_acc / W; m_acc++;
      end else begin
        e_valid = 0;
      end
    end else begin
      e_valid = 1; e_data = '0; m_z++;
      if (m_z == NZ) begin
        m_act = 0; m_fin = 1;
      end
    end
    @(posedge clk);
    #1;
    chk("oValid", bus.oValid, e_valid);
    chk("oData", bus.oData, e_data);
    chk("oDone", oDone, e_done);
    chk("oFrameCnt", oFrameCnt, e_fc);
    chk("oX", oX, e_x);
    chk("oY", oY, e_y);
    chk("oBusy", oBusy, m_act);
    chk("oReady", bus.oReady, m_act && (m_acc < NPIX));
    if (bus.oValid) begin
      if (after_done) begin
        gap_seen = nv_run;
        after_done = 0;
      end
      nv_run = 0;
    end else begin
      nv_run++;
    end
    if (oDone) after_done = 1;
  endtask

  task automatic run_frame(input string tag, input bit gapped, input bit hold, input bit pulses);
    int nval = 0, ndone = 0, i = 0;
    logic [7:0] outs[$];
    bit s, v, fin = 0;
    logic [7:0] d;
    step(0, 1, 0, 8'h00);
    while (!fin && i < 200) begin
      s = hold || (pulses && (i == 2 || i == 12));
      v = gapped ? (i % 2 == 0) : 1'b1;
      d = (m_acc < NPIX) ? 8'(m_acc + 1) : 8'hEE;
      step(0, s, v, d);
      if (bus.oValid) begin
        nval++;
        outs.push_back(bus.oData);
      end
      if (oDone) begin
        ndone++;
        fin = 1;
      end
      i++;
    end
    chk({tag, "_done_seen"}, fin, 1);
    chk({tag, "_valid_total"}, nval, NPIX + NZ);
    for (int j = 0; j < NPIX + NZ; j++)
      chk({tag, "_seq"}, (j < outs.size()) ? int'(outs[j]) : -1, (j < NPIX) ? j + 1 : 0);
  endtask

  typedef struct {
    bit r, s, v;
    logic [7:0] d;
    bit er, ev, eb;
    logic [7:0] ed;
  } vec_t;

  initial begin
    vec_t tbl[7];
    int i;
    bus.iValid = 0;
    bus.iData  = '0;

    tbl[0] = '{1, 0, 0, 8'h00, 0, 0, 0, 8'h00};
    tbl[1] = '{0, 0, 1, 8'hAA, 0, 0, 0, 8'h00};
    tbl[2] = '{0, 0, 1, 8'hAB, 0, 0, 0, 8'h00};
    tbl[3] = '{0, 1, 1, 8'h11, 1, 0, 1, 8'h00};
    tbl[4] = '{0, 0, 1, 8'h22, 1, 1, 1, 8'h22};
    tbl[5] = '{0, 0, 0, 8'h33, 1, 0, 1, 8'h22};
    tbl[6] = '{1, 0, 1, 8'h44, 0, 0, 0, 8'h00};
    for (int k = 0; k < 7; k++) begin
      step(tbl[k].r, tbl[k].s, tbl[k].v, tbl[k].d);
      chk("tbl_ready", bus.oReady, tbl[k].er);
      chk("tbl_valid", bus.oValid, tbl[k].ev);
      chk("tbl_busy", oBusy, tbl[k].eb);
      chk("tbl_data", bus.oData, tbl[k].ed);
    end
    step(0, 0, 0, 8'h00);

    run_frame("basic", 0, 0, 0);
    chk("basic_framecnt", oFrameCnt, 1);
    step(0, 0, 0, 8'h00);
    chk("done_one_cycle", oDone, 0);

    run_frame("gapped", 1, 0, 0);
    chk("gapped_x", oX, 3);
    chk("gapped_y", oY, 1);
    for (int k = 0; k < 3; k++) step(0, 0, 1, 8'h5A);
    chk("idle_ready", bus.oReady, 0);
    chk("idle_valid", bus.oValid, 0);
    chk("idle_x", oX, 3);
    chk("idle_y", oY, 1);

    step(1, 0, 0, 8'h00);
    step(0, 0, 0, 8'h00);
    run_frame("ignstart", 0, 0, 1);
    chk("ignstart_framecnt", oFrameCnt, 1);

    step(0, 1, 0, 8'h00);
    i = 0;
    while (m_z < 5 && i < 100) begin
      step(0, 0, 1, (m_acc < NPIX) ? 8'(m_acc + 1) : 8'h00);
      i++;
    end
    chk("flush_reached", m_z, 5);
    step(1, 0, 1, 8'h77);
    chk("rst_valid", bus.oValid, 0);
    chk("rst_ready", bus.oReady, 0);
    chk("rst_busy", oBusy, 0);
    chk("rst_framecnt", oFrameCnt, 0);
    step(0, 0, 0, 8'h00);
    run_frame("after_rst", 0, 0, 0);
    chk("after_rst_framecnt", oFrameCnt, 1);

    step(1, 0, 0, 8'h00);
    gap_seen = -1;
    after_done = 0;
    run_frame("b2b_1", 0, 1, 0);
    chk("b2b_fc1", oFrameCnt, 1);
    run_frame("b2b_2", 0, 1, 0);
    chk("b2b_gap", gap_seen, 2);
    chk("b2b_fc2", oFrameCnt, 2);

    for (int k = 0; k < 3000; k++)
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 7) == 0),
           1'($urandom_range(0, 1)), 8'($urandom));
    step(1, 0, 0, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
